// File: rtl/el2_lsu_trigger_ctl_if.sv
// Trigger-control bundle between the LSU trigger logic and decode/debug.
// lsu_trig_cnt exists only when LSU_TRIG_HITCNT_EN is defined.
interface el2_lsu_trigger_ctl_if #(
    parameter int TRIG_CNT_W = 8
);
    logic [3:0] lsu_trigger_match_m;
    logic       flush_m;
    logic [3:0] trig_chain;
    logic [3:0] trig_action;
    logic [3:0] dec_hit_clr;
    logic       dec_trig_ack;
    logic       lsu_trig_req;
    logic [3:0] lsu_trig_vec;
    logic       lsu_trig_halt;
    logic [3:0] lsu_trig_hit;
`ifdef LSU_TRIG_HITCNT_EN
    logic [4*TRIG_CNT_W-1:0] lsu_trig_cnt;

    modport master (
        input  lsu_trigger_match_m, flush_m, trig_chain, trig_action, dec_hit_clr, dec_trig_ack,
        output lsu_trig_req, lsu_trig_vec, lsu_trig_halt, lsu_trig_hit, lsu_trig_cnt
    );
    modport slave (
        output lsu_trigger_match_m, flush_m, trig_chain, trig_action, dec_hit_clr, dec_trig_ack,
        input  lsu_trig_req, lsu_trig_vec, lsu_trig_halt, lsu_trig_hit, lsu_trig_cnt
    );
`else
    localparam int unused_cnt_w = TRIG_CNT_W;

    modport master (
        input  lsu_trigger_match_m, flush_m, trig_chain, trig_action, dec_hit_clr, dec_trig_ack,
        output lsu_trig_req, lsu_trig_vec, lsu_trig_halt, lsu_trig_hit
    );
    modport slave (
        output lsu_trigger_match_m, flush_m, trig_chain, trig_action, dec_hit_clr, dec_trig_ack,
        input  lsu_trig_req, lsu_trig_vec, lsu_trig_halt, lsu_trig_hit
    );
`endif
endinterface

// File: rtl/el2_lsu_trigger_ctl.sv
// LSU data-trigger sequencer: flush kill, chain resolution, sticky hits, req/ack delivery.
// Optional saturating hit counters are built when LSU_TRIG_HITCNT_EN is defined.
module el2_lsu_trigger_ctl #(
    parameter int TRIG_CNT_W = 8
) (
    input logic                   clk,
    input logic                   rst_l,
    el2_lsu_trigger_ctl_if.master trig
);
    typedef enum logic {IDLE, PEND} state_t;

    state_t     state_q, state_d;
    logic [3:0] qual, fire;
    logic [3:0] hit_q;
    logic [3:0] vec_q, vec_d;
    logic       halt_q, halt_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] merged;
    logic       unused_chain;

    assign unused_chain = trig.trig_chain[1] ^ trig.trig_chain[3];

    assign qual = trig.lsu_trigger_match_m & {4{~trig.flush_m}};

    // A chained pair fires both halves only when both sides match together.
    assign fire[1:0] = trig.trig_chain[0] ? {2{&qual[1:0]}} : qual[1:0];
    assign fire[3:2] = trig.trig_chain[2] ? {2{&qual[3:2]}} : qual[3:2];

    assign merged = pend_q | fire;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            hit_q <= '0;
        end else begin
            hit_q <= (hit_q & ~trig.dec_hit_clr) | fire;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
            vec_q   <= '0;
            halt_q  <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            halt_q  <= halt_d;
            pend_q  <= pend_d;
        end
    end

    // Halt is computed from trig_action only when an event is captured into vec.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        halt_d  = halt_q;
        pend_d  = pend_q;
        unique case (state_q)
            IDLE: begin
                if (|fire) begin
                    state_d = PEND;
                    vec_d   = fire;
                    halt_d  = |(fire & trig.trig_action);
                    pend_d  = '0;
                end
            end
            PEND: begin
                if (trig.dec_trig_ack) begin
                    pend_d = '0;
                    if (|merged) begin
                        vec_d  = merged;
                        halt_d = |(merged & trig.trig_action);
                    end else begin
                        state_d = IDLE;
                        vec_d   = '0;
                        halt_d  = 1'b0;
                    end
                end else begin
                    pend_d = merged;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign trig.lsu_trig_req  = (state_q == PEND);
    assign trig.lsu_trig_vec  = vec_q;
    assign trig.lsu_trig_halt = halt_q;
    assign trig.lsu_trig_hit  = hit_q;

`ifdef LSU_TRIG_HITCNT_EN
    logic [4*TRIG_CNT_W-1:0] cnt_all;

    // A clear coinciding with a fire restarts the count at one, not zero.
    for (genvar i = 0; i < 4; i++) begin : g_cnt
        logic [TRIG_CNT_W-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                cnt_q <= '0;
            end else if (trig.dec_hit_clr[i]) begin
                cnt_q <= fire[i] ? TRIG_CNT_W'(1) : '0;
            end else if (fire[i] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + TRIG_CNT_W'(1);
            end
        end

        assign cnt_all[i*TRIG_CNT_W +: TRIG_CNT_W] = cnt_q;
    end

    assign trig.lsu_trig_cnt = cnt_all;
`else
    localparam int unused_cnt_w = TRIG_CNT_W;
`endif
endmodule

// File: tb/tb_el2_lsu_trigger_ctl.sv
// Directed bench for el2_lsu_trigger_ctl; counter checks run when LSU_TRIG_HITCNT_EN is defined.
module tb_el2_lsu_trigger_ctl;
`ifdef LSU_TRIG_HITCNT_EN
    localparam int W = 2;
`else
    localparam int W = 8;
`endif

    logic clk;
    logic rst_l;
    int   total_cnt;
    int   bad_cnt;

    el2_lsu_trigger_ctl_if #(.TRIG_CNT_W(W)) bus ();

    el2_lsu_trigger_ctl #(.TRIG_CNT_W(W)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .trig  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then let outputs settle just after the clock edge.
    task automatic applyStimulus(input logic [3:0] match, input logic flush,
                                 input logic [3:0] clr, input logic ack);
        bus.lsu_trigger_match_m = match;
        bus.flush_m             = flush;
        bus.dec_hit_clr         = clr;
        bus.dec_trig_ack        = ack;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst_l     = 1'b0;
        bus.lsu_trigger_match_m = '0;
        bus.flush_m      = 1'b0;
        bus.trig_chain   = '0;
        bus.trig_action  = '0;
        bus.dec_hit_clr  = '0;
        bus.dec_trig_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_req",  {31'd0, bus.lsu_trig_req},  32'd0);
        checkOutput("rst_vec",  {28'd0, bus.lsu_trig_vec},  32'd0);
        checkOutput("rst_halt", {31'd0, bus.lsu_trig_halt}, 32'd0);
        checkOutput("rst_hit",  {28'd0, bus.lsu_trig_hit},  32'd0);
        rst_l = 1'b1;

        // single trigger, one-cycle latency, ack returns to idle
        applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0);
        checkOutput("t1_req",  {31'd0, bus.lsu_trig_req},  32'd1);
        checkOutput("t1_vec",  {28'd0, bus.lsu_trig_vec},  32'h1);
        checkOutput("t1_halt", {31'd0, bus.lsu_trig_halt}, 32'd0);
        checkOutput("t1_hit",  {28'd0, bus.lsu_trig_hit},  32'h1);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b1);
        checkOutput("t1_ack_req", {31'd0, bus.lsu_trig_req}, 32'd0);
        checkOutput("t1_ack_vec", {28'd0, bus.lsu_trig_vec}, 32'h0);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b1);
        checkOutput("idle_ack_req", {31'd0, bus.lsu_trig_req}, 32'd0);
        applyStimulus(4'b0000, 1'b0, 4'b1111, 1'b0);
        checkOutput("clr_hit", {28'd0, bus.lsu_trig_hit}, 32'h0);

        // chain 0->1
        bus.trig_chain = 4'b0001;
        applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0);
        checkOutput("t2_half_req", {31'd0, bus.lsu_trig_req}, 32'd0);
        checkOutput("t2_half_hit", {28'd0, bus.lsu_trig_hit}, 32'h0);
        applyStimulus(4'b0011, 1'b0, 4'b0000, 1'b0);
        checkOutput("t2_req", {31'd0, bus.lsu_trig_req}, 32'd1);
        checkOutput("t2_vec", {28'd0, bus.lsu_trig_vec}, 32'h3);
        checkOutput("t2_hit", {28'd0, bus.lsu_trig_hit}, 32'h3);
        applyStimulus(4'b0000, 1'b0, 4'b1111, 1'b1);
        checkOutput("t2_ack_req", {31'd0, bus.lsu_trig_req}, 32'd0);

        // chain 2->3
        bus.trig_chain = 4'b0100;
        applyStimulus(4'b1000, 1'b0, 4'b0000, 1'b0);
        checkOutput("chain23_half_req", {31'd0, bus.lsu_trig_req}, 32'd0);
        applyStimulus(4'b1100, 1'b0, 4'b0000, 1'b0);
        checkOutput("chain23_vec", {28'd0, bus.lsu_trig_vec}, 32'hC);
        applyStimulus(4'b0000, 1'b0, 4'b1111, 1'b1);
        checkOutput("chain23_ack_req", {31'd0, bus.lsu_trig_req}, 32'd0);
        bus.trig_chain = 4'b0000;

        // flush kills, then halt action captured and held
        applyStimulus(4'b0100, 1'b1, 4'b0000, 1'b0);
        checkOutput("t3_flush_req", {31'd0, bus.lsu_trig_req}, 32'd0);
        checkOutput("t3_flush_hit", {28'd0, bus.lsu_trig_hit}, 32'h0);
        bus.trig_action = 4'b0100;
        applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0);
        checkOutput("t3_req",  {31'd0, bus.lsu_trig_req},  32'd1);
        checkOutput("t3_halt", {31'd0, bus.lsu_trig_halt}, 32'd1);
        bus.trig_action = 4'b0000;
        applyStimulus(4'b0000, 1'b1, 4'b0000, 1'b0);
        checkOutput("t3_held_halt", {31'd0, bus.lsu_trig_halt}, 32'd1);
        checkOutput("t3_flush_held_req", {31'd0, bus.lsu_trig_req}, 32'd1);
        applyStimulus(4'b0000, 1'b0, 4'b1111, 1'b1);
        checkOutput("t3_ack_halt", {31'd0, bus.lsu_trig_halt}, 32'd0);

        // merge during PEND, delivered back-to-back on ack
        applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0);
        applyStimulus(4'b1000, 1'b0, 4'b0000, 1'b0);
        checkOutput("t4_hold_vec", {28'd0, bus.lsu_trig_vec}, 32'h1);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
        checkOutput("t4_hold_req", {31'd0, bus.lsu_trig_req}, 32'd1);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b1);
        checkOutput("t4_b2b_req", {31'd0, bus.lsu_trig_req}, 32'd1);
        checkOutput("t4_b2b_vec", {28'd0, bus.lsu_trig_vec}, 32'h8);
        checkOutput("t4_hit",     {28'd0, bus.lsu_trig_hit}, 32'h9);
        // ack coinciding with a new fire plus pending bits
        applyStimulus(4'b0010, 1'b0, 4'b0000, 1'b0);
        applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b1);
        checkOutput("ack_fire_vec", {28'd0, bus.lsu_trig_vec}, 32'h6);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b1);
        checkOutput("t4_idle_req", {31'd0, bus.lsu_trig_req}, 32'd0);
        applyStimulus(4'b0000, 1'b0, 4'b1111, 1'b0);

        // set wins over clear
        applyStimulus(4'b0010, 1'b0, 4'b0010, 1'b0);
        checkOutput("t5_set_hit", {28'd0, bus.lsu_trig_hit}, 32'h2);
        applyStimulus(4'b0000, 1'b0, 4'b0010, 1'b1);
        checkOutput("t5_clr_hit", {28'd0, bus.lsu_trig_hit}, 32'h0);
        checkOutput("t5_req",     {31'd0, bus.lsu_trig_req}, 32'd0);

        // asynchronous reset mid-handshake drops the event
        applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0);
        bus.lsu_trigger_match_m = '0;
        #2 rst_l = 1'b0;
        #1;
        checkOutput("rst_mid_req", {31'd0, bus.lsu_trig_req}, 32'd0);
        checkOutput("rst_mid_vec", {28'd0, bus.lsu_trig_vec}, 32'h0);
        @(posedge clk);
        #1 rst_l = 1'b1;

`ifdef LSU_TRIG_HITCNT_EN
        applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b0);
        checkOutput("cnt_one", {30'd0, bus.lsu_trig_cnt[1:0]}, 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(4'b0001, 1'b0, 4'b0000, 1'b1);
        checkOutput("cnt_sat", {30'd0, bus.lsu_trig_cnt[1:0]}, 32'd3);
        applyStimulus(4'b0000, 1'b0, 4'b0001, 1'b1);
        checkOutput("cnt_clr", {30'd0, bus.lsu_trig_cnt[1:0]}, 32'd0);
        applyStimulus(4'b0001, 1'b0, 4'b0001, 1'b1);
        checkOutput("cnt_clr_fire", {30'd0, bus.lsu_trig_cnt[1:0]}, 32'd1);
        applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
